// File: rtl/axi_lite_arbiter_2to1_pkg.sv
// Shared types and constants for the 2-master / 1-slave AXI-Lite arbiter.
package ysyx_23060061_axi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

endpackage

// File: rtl/axi_lite_arbiter_2to1_if.sv
// AXI-Lite bundle (AR/R/AW/W/B); master modport drives requests, slave modport answers.
interface axi_lite_arbiter_2to1_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arvalid, input arready,
        input rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready
    );

    modport slave (
        input araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input awaddr, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );

endinterface

// File: rtl/axi_lite_arbiter_2to1_rr_pick2.sv
// Combinational two-way round-robin picker: a tie goes to the master that did not win last.
module rr_pick2
    import ysyx_23060061_axi_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_owner,
    output logic o_grant_valid,
    output logic o_grant_idx
);

    assign o_grant_valid = i_req0 | i_req1;
    assign o_grant_idx   = (i_req0 & i_req1) ? ~i_last_owner : (i_req1 ? M_LSU : M_IFU);

endmodule

// File: rtl/axi_lite_arbiter_2to1.sv
// Shares one AXI-Lite slave between IFU (m0) and LSU (m1); one transaction in flight,
// round-robin grant held until the response handshake.
module axi_lite_arbiter_2to1
    import ysyx_23060061_axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    axi_lite_arbiter_2to1_if.slave  m0,
    axi_lite_arbiter_2to1_if.slave  m1,
    axi_lite_arbiter_2to1_if.master s
);

    state_e r_state, w_state_nxt;
    logic   r_owner, w_owner_nxt;
    logic   r_last_owner, w_last_owner_nxt;

    logic w_wreq0, w_wreq1, w_req0, w_req1;
    logic w_grant_valid, w_grant_idx;

    logic [ADDR_W-1:0]   w_sel_araddr, w_sel_awaddr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [DATA_W/8-1:0] w_sel_wstrb;
    logic                w_sel_arvalid, w_sel_rready, w_sel_awvalid, w_sel_wvalid, w_sel_bready;

    assign w_wreq0 = m0.awvalid & m0.wvalid;
    assign w_wreq1 = m1.awvalid & m1.wvalid;
    assign w_req0  = w_wreq0 | m0.arvalid;
    assign w_req1  = w_wreq1 | m1.arvalid;

    rr_pick2 u_rr_pick2 (
        .i_req0        (w_req0),
        .i_req1        (w_req1),
        .i_last_owner  (r_last_owner),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    assign w_sel_araddr  = r_owner ? m1.araddr  : m0.araddr;
    assign w_sel_arvalid = r_owner ? m1.arvalid : m0.arvalid;
    assign w_sel_rready  = r_owner ? m1.rready  : m0.rready;
    assign w_sel_awaddr  = r_owner ? m1.awaddr  : m0.awaddr;
    assign w_sel_awvalid = r_owner ? m1.awvalid : m0.awvalid;
    assign w_sel_wdata   = r_owner ? m1.wdata   : m0.wdata;
    assign w_sel_wstrb   = r_owner ? m1.wstrb   : m0.wstrb;
    assign w_sel_wvalid  = r_owner ? m1.wvalid  : m0.wvalid;
    assign w_sel_bready  = r_owner ? m1.bready  : m0.bready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= M_IFU;
            r_last_owner <= M_LSU;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        unique case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_owner_nxt      = w_grant_idx;
                    w_last_owner_nxt = w_grant_idx;
                    // A master asserting both a read and a full write gets the write first.
                    w_state_nxt      = (w_grant_idx ? w_wreq1 : w_wreq0) ? WRITE : READ;
                end
            end
            READ:    if (s.rvalid && s.rready) w_state_nxt = IDLE;
            WRITE:   if (s.bvalid && s.bready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s.araddr   = '0;
        s.arvalid  = 1'b0;
        s.rready   = 1'b0;
        s.awaddr   = '0;
        s.awvalid  = 1'b0;
        s.wdata    = '0;
        s.wstrb    = '0;
        s.wvalid   = 1'b0;
        s.bready   = 1'b0;
        m0.arready = 1'b0;
        m0.rdata   = '0;
        m0.rresp   = '0;
        m0.rvalid  = 1'b0;
        m0.awready = 1'b0;
        m0.wready  = 1'b0;
        m0.bresp   = '0;
        m0.bvalid  = 1'b0;
        m1.arready = 1'b0;
        m1.rdata   = '0;
        m1.rresp   = '0;
        m1.rvalid  = 1'b0;
        m1.awready = 1'b0;
        m1.wready  = 1'b0;
        m1.bresp   = '0;
        m1.bvalid  = 1'b0;
        unique case (r_state)
            READ: begin
                s.araddr  = w_sel_araddr;
                s.arvalid = w_sel_arvalid;
                s.rready  = w_sel_rready;
                if (r_owner == M_LSU) begin
                    m1.arready = s.arready;
                    m1.rdata   = s.rdata;
                    m1.rresp   = s.rresp;
                    m1.rvalid  = s.rvalid;
                end else begin
                    m0.arready = s.arready;
                    m0.rdata   = s.rdata;
                    m0.rresp   = s.rresp;
                    m0.rvalid  = s.rvalid;
                end
            end
            WRITE: begin
                s.awaddr  = w_sel_awaddr;
                s.awvalid = w_sel_awvalid;
                s.wdata   = w_sel_wdata;
                s.wstrb   = w_sel_wstrb;
                s.wvalid  = w_sel_wvalid;
                s.bready  = w_sel_bready;
                if (r_owner == M_LSU) begin
                    m1.awready = s.awready;
                    m1.wready  = s.wready;
                    m1.bresp   = s.bresp;
                    m1.bvalid  = s.bvalid;
                end else begin
                    m0.awready = s.awready;
                    m0.wready  = s.wready;
                    m0.bresp   = s.bresp;
                    m0.bvalid  = s.bvalid;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/axi_lite_arbiter_2to1.md
Name: axi_lite_arbiter_2to1

Overview:
- 2-master / 1-slave AXI-Lite arbiter sitting downstream of the IFU (master 0) and LSU (master 1).
- Lets both fetch and load/store traffic share one SRAM slave instead of separate InstMem/DataMem instances.
- Only one transaction is outstanding at a time. Round-robin grant, held until the response handshake completes.

Parameters:
ADDR_W, 32, address width of all AR/AW channels
DATA_W, 32, data width of R/W channels; strobe width is DATA_W/8

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
m0_araddr/m0_arvalid in ADDR_W/1; m0_arready out 1  IFU read address
m0_rdata out DATA_W; m0_rresp out 2; m0_rvalid out 1; m0_rready in 1  IFU read data
m0_awaddr/m0_awvalid in ADDR_W/1; m0_awready out 1; m0_wdata/m0_wstrb/m0_wvalid in DATA_W/DATA_W/8/1; m0_wready out 1  IFU write (normally tied off)
m0_bresp out 2; m0_bvalid out 1; m0_bready in 1  IFU write response
m1_*  same 17 signals and directions as m0_*  LSU port
s_araddr/s_arvalid out ADDR_W/1; s_arready in 1  slave read address
s_rdata in DATA_W; s_rresp in 2; s_rvalid in 1; s_rready out 1  slave read data
s_awaddr/s_awvalid out ADDR_W/1; s_awready in 1; s_wdata/s_wstrb/s_wvalid out DATA_W/DATA_W/8/1; s_wready in 1  slave write
s_bresp in 2; s_bvalid in 1; s_bready out 1  slave write response

Behaviour:
- FSM states: IDLE, READ, WRITE. Registers: state, owner (0/1), last_owner.
- Reset (rst=1 at posedge): state=IDLE, owner=0, last_owner=1. Every output valid/ready/data/resp is 0 while in IDLE.
- Request of master i: wreq_i = awvalid_i & wvalid_i; rreq_i = arvalid_i; req_i = wreq_i | rreq_i.
- IDLE: if any req_i, grant master i. On a tie, grant !last_owner. At the edge set owner=i, last_owner=i.
  - state=WRITE if wreq_i, else READ. Write wins when one master asserts both.
  - No slave valid is driven in IDLE, so there is a fixed 1-cycle arbitration bubble.
- READ: combinationally route owner's AR and R channels to the slave and back.
  - s_araddr/s_arvalid = owner's; owner arready = s_arready; owner rdata/rresp/rvalid = slave's; s_rready = owner rready.
  - Exit to IDLE at the edge where s_rvalid & s_rready.
- WRITE: route owner's AW, W and B channels the same way. AW and W handshakes may complete in either order or the same cycle.
  - Exit to IDLE at the edge where s_bvalid & s_bready.
- Non-owner master, and both masters in IDLE: arready/awready/wready/rvalid/bvalid = 0; rdata/rresp/bresp = 0.
- Slave outputs in IDLE: valids=0, s_rready=0, s_bready=0, address/data/strb=0.
- The AW/AR handshake and the response handshake may occur in the same cycle (zero-latency slave). The FSM must still exit on the response.
- The non-owner's request is held pending (its ready stays 0) and is granted in the IDLE cycle after exit.
- Back-to-back requests from the same master with the other idle: that master is re-granted every time. Minimum period = slave latency + 1 cycle.
- rst asserted mid-transaction: return to IDLE at that edge and drop the in-flight response. The top resets the slave in the same cycle.
- The arbiter does not check AXI protocol violations (e.g. valid dropped before ready).
- resp codes pass through unmodified; no address decoding.

Decomposition:
- Package ysyx_23060061_axi_pkg holds: state enum (IDLE/READ/WRITE); resp constants OKAY=2'b00, SLVERR=2'b10; master index constants M_IFU=0, M_LSU=1.
- One sub-module: rr_pick2, a combinational round-robin picker (inputs req0, req1, last_owner; outputs grant_valid, grant_idx). The FSM and the muxing stay in the top module.

Test Plan:
1. Reset: hold rst 2 cycles with m0_arvalid=1 -> all outputs 0 during reset. s_arvalid first rises 2 cycles after rst deasserts (one IDLE grant cycle, then READ) with s_araddr=m0_araddr=0x80000000.
2. IFU read: m0 araddr 0x80000004, slave returns 0x00100073 with 1-cycle latency -> m0_rdata=0x00100073, m0_rresp=0, FSM back to IDLE. m1 sees no valid/ready at any point.
3. LSU write: m1 awaddr 0x80001000, wdata 0xDEADBEEF, wstrb 4'b0011; slave accepts W one cycle before AW -> s_* carries identical values, m1_bvalid pulses once, exit after the B handshake.
4. Simultaneous m0 read and m1 read right after reset -> m0 granted first (last_owner=1). m1 granted in the IDLE cycle following m0's R handshake, with m1_arready held 0 until then.
5. Repeat tie after scenario 4 -> m0 granted (last_owner=1 after m1's grant). Then m0 requests again while m1 is pending -> m1 granted next, confirming alternation.
6. Assert rst while in WRITE before the B handshake -> next cycle state=IDLE and all outputs 0. A fresh m1 write after reset completes normally.
